// File: rtl/ram_bus_arbiter.sv
// Two-port req/ack arbiter in front of a single synchronous RAM port.
// Each granted access runs IDLE -> ACCESS -> CAPTURE -> ACK with a fixed four-cycle cadence.
module ram_bus_arbiter #(
  parameter int ADLINES     = 8,
  parameter int DATALINES   = 16,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADLINES-1:0]   p0_addr,
  input  logic [DATALINES-1:0] p0_wdata,
  output logic                 p0_ack,
  output logic [DATALINES-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADLINES-1:0]   p1_addr,
  input  logic [DATALINES-1:0] p1_wdata,
  output logic                 p1_ack,
  output logic [DATALINES-1:0] p1_rdata,
  output logic [ADLINES-1:0]   addressbus,
  output logic                 read,
  output logic                 write,
  output logic [DATALINES-1:0] toram,
  input  logic [DATALINES-1:0] fromram,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t state, state_nx;
  logic   gnt, gnt_nx;
  logic   last_grant;
  logic   op_we;
  logic   sel_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
    end
  end

  // On contention, round robin hands the bus to whichever port did not win last time
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_nx = ACCESS;
          if (p0_req && p1_req)
            gnt_nx = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
          else
            gnt_nx = p1_req;
        end
      end
      ACCESS:  state_nx = CAPTURE;
      CAPTURE: state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sel_we = gnt_nx ? p1_we : p0_we;

  // Bus and handshake outputs are all registered; the address and write data stay put after an access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addressbus <= '0;
      toram      <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      busy       <= 1'b0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      op_we      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (state_nx == ACCESS) begin
            addressbus <= gnt_nx ? p1_addr : p0_addr;
            toram      <= gnt_nx ? p1_wdata : p0_wdata;
            op_we      <= sel_we;
            read       <= ~sel_we;
            write      <= sel_we;
            busy       <= 1'b1;
          end
        end
        ACCESS: begin
          read       <= 1'b0;
          write      <= 1'b0;
          last_grant <= gnt;
        end
        CAPTURE: begin
          if (!op_we) begin
            if (gnt) p1_rdata <= fromram;
            else     p0_rdata <= fromram;
          end
          if (gnt) p1_ack <= 1'b1;
          else     p0_ack <= 1'b1;
        end
        ACK: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: a round-robin instance with a RAM model and a fixed-priority instance.
module tb_ram_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
  logic [AW-1:0] p0_addr, p1_addr, addressbus;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, toram, fromram;
  logic          read, write, busy;

  logic          p0_req_f, p0_we_f, p0_ack_f, p1_req_f, p1_we_f, p1_ack_f;
  logic [AW-1:0] p0_addr_f, p1_addr_f, addressbus_f;
  logic [DW-1:0] p0_wdata_f, p1_wdata_f, p0_rdata_f, p1_rdata_f, toram_f, fromram_f;
  logic          read_f, write_f, busy_f;

  ram_bus_arbiter #(.ADLINES(AW), .DATALINES(DW), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .addressbus(addressbus), .read(read), .write(write), .toram(toram),
    .fromram(fromram), .busy(busy)
  );

  ram_bus_arbiter #(.ADLINES(AW), .DATALINES(DW), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req_f), .p0_we(p0_we_f), .p0_addr(p0_addr_f), .p0_wdata(p0_wdata_f),
    .p0_ack(p0_ack_f), .p0_rdata(p0_rdata_f),
    .p1_req(p1_req_f), .p1_we(p1_we_f), .p1_addr(p1_addr_f), .p1_wdata(p1_wdata_f),
    .p1_ack(p1_ack_f), .p1_rdata(p1_rdata_f),
    .addressbus(addressbus_f), .read(read_f), .write(write_f), .toram(toram_f),
    .fromram(fromram_f), .busy(busy_f)
  );

  // Synchronous RAM: samples strobes at the rising edge, read data valid the cycle after
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (write) mem[addressbus] <= toram;
    if (read)  fromram <= mem[addressbus];
  end

  // Fixed-priority instance sees a RAM whose contents encode the address
  always @(posedge clk) begin
    if (read_f) fromram_f <= {8'hC3, addressbus_f};
  end

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
  } sb_t;

  vec_t vecs [10];
  sb_t  sbq [$];
  int   total = 0;
  int   bad   = 0;
  bit   sb_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    chk("rw_excl", 32'(read && write), 32'(0));
    chk("ack_excl", 32'(p0_ack && p1_ack), 32'(0));
    chk("ack_excl_f", 32'(p0_ack_f && p1_ack_f), 32'(0));
    if (sb_on && (p0_ack || p1_ack)) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_ack", 32'(1), 32'(0));
      end else begin
        e = sbq.pop_front();
        chk("sb_port", 32'(p1_ack), 32'(e.port));
        chk("sb_rdata", 32'(e.port ? p1_rdata : p0_rdata), 32'(e.rdata));
      end
    end
  endtask

  task automatic set_req(input logic port, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    end else begin
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    end
  endtask

  task automatic do_txn(input vec_t v);
    sbq.push_back('{port: v.port, rdata: v.exp});
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
    tick();
    chk("strobe_rd", 32'(read), 32'(!v.we));
    chk("strobe_wr", 32'(write), 32'(v.we));
    chk("addr", 32'(addressbus), 32'(v.addr));
    if (v.we) chk("toram", 32'(toram), 32'(v.wdata));
    chk("busy_acc", 32'(busy), 32'(1));
    tick();
    chk("strobe_off", 32'(read | write), 32'(0));
    chk("ack_early", 32'(p0_ack | p1_ack), 32'(0));
    tick();
    chk("ack_port", 32'(v.port ? p1_ack : p0_ack), 32'(1));
    chk("ack_other", 32'(v.port ? p0_ack : p1_ack), 32'(0));
    set_req(v.port, 1'b0, 1'b0, '0, '0);
    tick();
    chk("idle_busy", 32'(busy), 32'(0));
    chk("ack_clear", 32'(p0_ack | p1_ack), 32'(0));
  endtask

  initial begin
    int   nacks;
    int   cyc;
    int   n0;
    bit   p1_seen;
    logic ack_port [4];
    int   ack_at [4];

    //            port  we    addr   wdata     expected rdata of that port
    vecs[0] = '{1'b1, 1'b1, 8'h05, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 8'h05, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 8'h05, 16'h0000, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 16'hA5A5, 16'h1234};
    vecs[6] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'hA5A5};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 16'h0001, 16'h1234};
    vecs[8] = '{1'b1, 1'b1, 8'h00, 16'hFFFF, 16'hA5A5};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'hFFFF};

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    p0_req_f = 1'b0; p0_we_f = 1'b0; p0_addr_f = '0; p0_wdata_f = '0;
    p1_req_f = 1'b0; p1_we_f = 1'b0; p1_addr_f = '0; p1_wdata_f = '0;

    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_strobes", 32'({read, write}), 32'(0));
    chk("rst_addr", 32'(addressbus), 32'(0));
    chk("rst_toram", 32'(toram), 32'(0));
    chk("rst_acks", 32'({p0_ack, p1_ack}), 32'(0));
    chk("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'(0));
    rst_n = 1'b1;
    tick();

    // Reset asserted between edges while a write strobe is up
    set_req(1'b1, 1'b1, 1'b1, 8'h40, 16'h5555);
    tick();
    chk("pre_rst_write", 32'(write), 32'(1));
    chk("pre_rst_busy", 32'(busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_write", 32'(write), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_ack", 32'({p0_ack, p1_ack}), 32'(0));
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    chk("post_rst_outs", 32'({read, write, busy, p0_ack, p1_ack}), 32'(0));
    chk("post_rst_addr", 32'(addressbus), 32'(0));
    chk("post_rst_toram", 32'(toram), 32'(0));
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'(0));

    sb_on = 1'b1;
    for (int i = 0; i < 10; i++) do_txn(vecs[i]);
    sb_on = 1'b0;
    chk("sb_drained", 32'(sbq.size()), 32'(0));

    // Request withdrawn in the strobe cycle still completes
    set_req(1'b0, 1'b1, 1'b0, 8'h05, '0);
    tick();
    chk("drop_rd", 32'(read), 32'(1));
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("drop_ack", 32'(p0_ack), 32'(1));
    chk("drop_rdata", 32'(p0_rdata), 32'(16'hBEEF));
    tick();
    chk("drop_busy", 32'(busy), 32'(0));
    chk("drop_ack_clr", 32'(p0_ack), 32'(0));
    tick();
    chk("drop_no_regrant", 32'(busy), 32'(0));

    // Round robin: both ports held from reset
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 8'h05, '0);
    set_req(1'b1, 1'b1, 1'b0, 8'h10, '0);
    tick();
    rst_n = 1'b1;
    nacks = 0;
    cyc = 0;
    while (nacks < 4 && cyc < 30) begin
      tick();
      cyc++;
      if (p0_ack || p1_ack) begin
        ack_port[nacks] = p1_ack;
        ack_at[nacks] = cyc;
        chk("rr_rdata", 32'(p1_ack ? p1_rdata : p0_rdata), 32'(p1_ack ? 16'h1234 : 16'hBEEF));
        nacks++;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rr_count", 32'(nacks), 32'(4));
    for (int k = 0; k < nacks; k++) begin
      chk("rr_port", 32'(ack_port[k]), 32'(k % 2));
      if (k > 0) chk("rr_spacing", 32'(ack_at[k] - ack_at[k-1]), 32'(4));
    end
    tick();
    tick();
    chk("rr_idle", 32'(busy), 32'(0));

    // Fixed priority: port 1 only served once port 0 lets go
    p0_req_f = 1'b1; p0_addr_f = 8'h22;
    p1_req_f = 1'b1; p1_addr_f = 8'h33;
    n0 = 0;
    p1_seen = 1'b0;
    cyc = 0;
    while (!p1_seen && cyc < 40) begin
      tick();
      cyc++;
      if (p0_ack_f) begin
        chk("fp_p0_rdata", 32'(p0_rdata_f), 32'(16'hC322));
        n0++;
        if (n0 == 3) p0_req_f = 1'b0;
      end
      if (p1_ack_f) begin
        chk("fp_p1_after_drop", 32'(n0), 32'(3));
        chk("fp_p1_rdata", 32'(p1_rdata_f), 32'(16'hC333));
        p1_seen = 1'b1;
        p1_req_f = 1'b0;
      end
    end
    chk("fp_p1_served", 32'(p1_seen), 32'(1));
    chk("fp_p0_count", 32'(n0), 32'(3));
    tick();
    tick();
    chk("fp_idle", 32'(busy_f), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single synchronous RAM port (address, read, write, write-data, read-data) between two requesters: port 0 (control unit) and port 1 (program loader / debug access).
- Each port uses a req/ack handshake; the arbiter serialises accesses, drives the RAM bus, captures read data and returns it with a one-cycle ack pulse.
- Sits between the control unit and the RAM in the top level.

Parameters:
- ADLINES, 8, RAM address width
- DATALINES, 16, RAM data width
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, port 0 wins

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 access request, held until p0_ack
- p0_we  in  1  port 0: 1 = write, 0 = read
- p0_addr  in  ADLINES  port 0 address
- p0_wdata  in  DATALINES  port 0 write data
- p0_ack  out  1  port 0 completion pulse, one cycle
- p0_rdata  out  DATALINES  port 0 read data, valid while p0_ack = 1
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- addressbus  out  ADLINES  RAM address
- read  out  1  RAM read strobe
- write  out  1  RAM write strobe
- toram  out  DATALINES  RAM write data
- fromram  in  DATALINES  RAM read data, valid one cycle after read
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous, rst_n low:
  - All outputs go to 0 and the state goes to IDLE.
  - last_grant = 1, so port 0 wins the first tie.
  - Reset mid-transaction abandons the access with no ack. Any RAM strobe drops immediately.
- Registered outputs only. The requester must hold req, we, addr and wdata stable from req assertion until ack.
- States: IDLE -> ACCESS -> CAPTURE -> ACK -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req with ROUND_ROBIN = 1: grant the port that is not last_grant.
  - Both req with ROUND_ROBIN = 0: grant port 0.
  - On grant, register the granted port's addr into addressbus and wdata into toram; set read = ~we or write = we; set busy; go to ACCESS.
- ACCESS:
  - The strobe is high for exactly this one cycle (RAM samples at the closing edge).
  - At that edge, clear read/write and update last_grant. Go to CAPTURE.
- CAPTURE:
  - fromram is valid. On a read, register it into the granted port's rdata. On a write, rdata holds its previous value.
  - Set the granted port's ack. Go to ACK.
- ACK:
  - Granted ack is high for exactly this cycle. Requests from both ports are ignored.
  - At the edge, clear ack and busy. Go to IDLE.
  - A req still high in the following IDLE cycle is a new request.
- Fixed latency:
  - req first sampled at edge N.
  - Strobe high in cycle N+1.
  - ack high in cycle N+3.
  - Earliest next grant at edge N+4.
- The ungranted requester waits, held off for at most one full transaction when ROUND_ROBIN = 1.
- addressbus and toram hold their last values after an access; only the strobes return to 0.
- read and write are never high together. Never both acks in one cycle.
- A req dropped after grant is not aborted: the access completes and ack still pulses.
- prdata persists until that port's next read.

Test Plan:
- Reset with rst_n low mid-ACCESS (write=1) -> write, ack and busy go to 0 immediately without waiting for clk; after release, state IDLE, all outputs 0.
- p0 read, addr 0x05, RAM[5] = 0xBEEF -> read = 1, addressbus = 0x05 for exactly one cycle; p0_ack high 2 cycles later with p0_rdata = 0xBEEF; p1_ack stays 0.
- p1 write, addr 0x10, data 0x1234 -> write = 1 for one cycle, toram = 0x1234; p1_ack pulse; a following p0 read of 0x10 returns 0x1234.
- ROUND_ROBIN = 1, both req held continuously from reset -> grants alternate p0, p1, p0, p1; acks spaced 4 cycles apart; no two acks in the same cycle.
- ROUND_ROBIN = 0, both req held -> p0 is granted every transaction; p1_ack appears only after p0_req is dropped.
- p0_req dropped one cycle after grant -> strobe still issues and p0_ack still pulses; arbiter returns to IDLE with busy = 0.
